// File: rtl/digit_serial_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | digit_serial_adder_if: start/busy/done handshake and operand bundle   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface digit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/digit_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | digit_serial_adder: DIGIT-bits-per-cycle add/sub over WIDTH/DIGIT clks |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_serial_adder_if.slave  bus
);
  localparam int c_n     = WIDTH / DIGIT;
  localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);
  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_run  = 1'b1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("digit_serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
    end
  endgenerate

  logic [0:0]         r_state;
  logic [0:0]         w_state_next;
  logic               w_busy;
  logic               w_load;
  logic               w_step;
  logic               w_finish;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   w_a_shift;
  logic [WIDTH-1:0]   w_b_shift;
  logic [WIDTH-1:0]   w_res_next;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_s;
  logic               r_cout;
  logic               r_ovf;
  logic               r_done;
  logic [DIGIT:0]     w_digit;
  logic               w_msb_cin;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (bus.start)        w_state_next = c_run;
      c_run:   if (r_cnt == c_last)  w_state_next = c_idle;
      default:                       w_state_next = c_idle;
    endcase
  end

  always_comb begin
    w_busy   = (r_state == c_run);
    w_load   = (r_state == c_idle) && bus.start;
    w_step   = (r_state == c_run);
    w_finish = (r_state == c_run) && (r_cnt == c_last);
  end

  // Carry into the digit MSB is recovered from the sum bit, avoiding a second adder.
  assign w_digit   = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  assign w_msb_cin = w_digit[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];

  generate
    if (DIGIT == WIDTH) begin : g_single
      assign w_a_shift  = '0;
      assign w_b_shift  = '0;
      assign w_res_next = w_digit[DIGIT-1:0];
    end else begin : g_multi
      logic [WIDTH-DIGIT-1:0] r_res;

      assign w_a_shift  = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
      assign w_b_shift  = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
      assign w_res_next = {w_digit[DIGIT-1:0], r_res};

      always_ff @(posedge clk) begin
        if (!rst_n)      r_res <= '0;
        else if (w_step) r_res <= w_res_next[WIDTH-1:DIGIT];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_a     <= bus.a;
        r_b     <= bus.b ^ {WIDTH{bus.sub}};
        r_carry <= bus.cin ^ bus.sub;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_a     <= w_a_shift;
        r_b     <= w_b_shift;
        r_carry <= w_digit[DIGIT];
        if (w_finish) begin
          r_cnt  <= '0;
          r_s    <= w_res_next;
          r_cout <= w_digit[DIGIT];
          r_ovf  <= w_msb_cin ^ w_digit[DIGIT];
        end else begin
          r_cnt  <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign bus.s    = r_s;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_digit_serial_adder: directed vectors at 8/2 plus 4-bit sweeps      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_digit_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  digit_serial_adder_if #(.WIDTH(8)) m ();
  digit_serial_adder_if #(.WIDTH(4)) w1 ();
  digit_serial_adder_if #(.WIDTH(4)) w2 ();
  digit_serial_adder_if #(.WIDTH(4)) w4 ();

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut (.clk(clk), .rst_n(rst_n), .bus(m));
  digit_serial_adder #(.WIDTH(4), .DIGIT(1)) u_sw1 (.clk(clk), .rst_n(rst_n), .bus(w1));
  digit_serial_adder #(.WIDTH(4), .DIGIT(2)) u_sw2 (.clk(clk), .rst_n(rst_n), .bus(w2));
  digit_serial_adder #(.WIDTH(4), .DIGIT(4)) u_sw4 (.clk(clk), .rst_n(rst_n), .bus(w4));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] last_s;
  vec_t       tbl[8];
  int         lat[3];
  logic [4:0] res[3];
  logic       ovr[3];
  int         expl[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // One 8-bit operation; returns at the negedge where done is seen.
  task automatic run8(input vec_t v, input int inject, input string name);
    int lat8;
    int busy_cnt;
    bit stable;
    m.a = v.a; m.b = v.b; m.cin = v.cin; m.sub = v.sub; m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    lat8 = -1; busy_cnt = 0; stable = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (m.done) begin
        lat8 = c;
        break;
      end
      if (m.busy) busy_cnt++;
      if (m.s !== last_s) stable = 1'b0;
      if (c == inject) begin
        m.start = 1'b1; m.a = 8'h11; m.b = 8'h22; m.sub = ~v.sub; m.cin = ~v.cin;
      end else begin
        m.start = 1'b0;
      end
      @(negedge clk);
    end
    m.start = 1'b0;
    chk({name, " latency"}, lat8, 4);
    chk({name, " busy_cycles"}, busy_cnt, 4);
    chk({name, " s_stable_in_run"}, {31'd0, stable}, 1);
    chk({name, " busy_with_done"}, {31'd0, m.busy}, 0);
    chk({name, " s"}, {24'd0, m.s}, {24'd0, v.s});
    chk({name, " cout"}, {31'd0, m.cout}, {31'd0, v.cout});
    chk({name, " ovf"}, {31'd0, m.ovf}, {31'd0, v.ovf});
    last_s = v.s;
  endtask

  task automatic grab(input int i, input int c, input logic d, input logic [4:0] r, input logic o);
    if (d && lat[i] < 0) begin
      lat[i] = c;
      res[i] = r;
      ovr[i] = o;
    end
  endtask

  initial begin
    int         extra;
    logic [3:0] av, bv, bb;
    logic [4:0] full;
    logic       eo;

    rst_n = 1'b0;
    m.start = 1'b0; m.sub = 1'b0; m.a = '0; m.b = '0; m.cin = 1'b0;
    w1.start = 1'b0; w1.sub = 1'b0; w1.a = '0; w1.b = '0; w1.cin = 1'b0;
    w2.start = 1'b0; w2.sub = 1'b0; w2.a = '0; w2.b = '0; w2.cin = 1'b0;
    w4.start = 1'b0; w4.sub = 1'b0; w4.a = '0; w4.b = '0; w4.cin = 1'b0;
    last_s = 8'h00;
    expl[0] = 4; expl[1] = 2; expl[2] = 1;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[6] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, m.busy}, 0);
    chk("reset done", {31'd0, m.done}, 0);
    chk("reset s", {24'd0, m.s}, 0);
    chk("reset cout", {31'd0, m.cout}, 0);
    chk("reset ovf", {31'd0, m.ovf}, 0);
    chk("reset sweep busy", {29'd0, w1.busy, w2.busy, w4.busy}, 0);
    chk("reset sweep done", {29'd0, w1.done, w2.done, w4.done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run8(tbl[i], -1, $sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d done_one_cycle", i), {31'd0, m.done}, 0);
    end

    // start pulsed mid-run must neither disturb nor queue
    run8(tbl[0], 1, "ignore_start");
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m.done || m.busy) extra++;
    end
    chk("ignore_start no_second_op", extra, 0);
    chk("ignore_start s_held", {24'd0, m.s}, 32'h96);

    // back-to-back: second start lands in the done cycle
    run8(tbl[1], -1, "b2b_first");
    run8(tbl[3], -1, "b2b_second");
    @(negedge clk);
    chk("b2b done_one_cycle", {31'd0, m.done}, 0);

    // reset after digit 2 of an operation
    m.a = 8'h5A; m.b = 8'h3C; m.cin = 1'b0; m.sub = 1'b0; m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset busy", {31'd0, m.busy}, 0);
    chk("midreset done", {31'd0, m.done}, 0);
    chk("midreset s", {24'd0, m.s}, 0);
    chk("midreset cout", {31'd0, m.cout}, 0);
    chk("midreset ovf", {31'd0, m.ovf}, 0);
    rst_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m.done || m.busy) extra++;
    end
    chk("midreset no_done", extra, 0);
    last_s = 8'h00;
    run8(tbl[4], -1, "after_reset");
    @(negedge clk);

    // exhaustive 4-bit sweep for DIGIT = 1, 2, 4
    for (int sb = 0; sb < 2; sb++) begin
      for (int cn = 0; cn < 2; cn++) begin
        for (int ai = 0; ai < 16; ai++) begin
          for (int bi = 0; bi < 16; bi++) begin
            av = 4'(ai); bv = 4'(bi);
            w1.a = av; w1.b = bv; w1.cin = cn[0]; w1.sub = sb[0]; w1.start = 1'b1;
            w2.a = av; w2.b = bv; w2.cin = cn[0]; w2.sub = sb[0]; w2.start = 1'b1;
            w4.a = av; w4.b = bv; w4.cin = cn[0]; w4.sub = sb[0]; w4.start = 1'b1;
            @(negedge clk);
            w1.start = 1'b0; w2.start = 1'b0; w4.start = 1'b0;
            for (int i = 0; i < 3; i++) begin
              lat[i] = -1; res[i] = '0; ovr[i] = 1'b0;
            end
            for (int c = 0; c <= 5; c++) begin
              grab(0, c, w1.done, {w1.cout, w1.s}, w1.ovf);
              grab(1, c, w2.done, {w2.cout, w2.s}, w2.ovf);
              grab(2, c, w4.done, {w4.cout, w4.s}, w4.ovf);
              if (c < 5) @(negedge clk);
            end
            bb   = bv ^ {4{sb[0]}};
            full = {1'b0, av} + {1'b0, bb} + {4'd0, cn[0] ^ sb[0]};
            eo   = (av[3] == bb[3]) && (full[3] != av[3]);
            for (int i = 0; i < 3; i++) begin
              chk($sformatf("sweep D%0d a=%0h b=%0h cin=%0d sub=%0d lat", 4 / expl[i], ai, bi, cn, sb),
                  lat[i], expl[i]);
              chk($sformatf("sweep D%0d a=%0h b=%0h cin=%0d sub=%0d cout_s", 4 / expl[i], ai, bi, cn, sb),
                  {27'd0, res[i]}, {27'd0, full});
              chk($sformatf("sweep D%0d a=%0h b=%0h cin=%0d sub=%0d ovf", 4 / expl[i], ai, bi, cn, sb),
                  {31'd0, ovr[i]}, {31'd0, eo});
            end
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised multi-cycle adder/subtractor processing `DIGIT` bits per clock over `WIDTH/DIGIT` cycles, trading latency for area versus a full-width ripple-carry adder. It adds a start/busy/done handshake, a subtract mode, carry/borrow-out and signed overflow. It sits in the arithmetic datapath wherever a full-width combinational adder is too large or too slow for the clock.

## Interface
- `WIDTH`, 8: operand/result width in bits; must be ≥ 1.
- `DIGIT`, 2: bits processed per cycle; 1 ≤ `DIGIT` ≤ `WIDTH`, and `WIDTH % DIGIT == 0`. Elaboration fails otherwise.
- Derived: `N = WIDTH/DIGIT` digit cycles; counter width is `$clog2(N)`, minimum 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: request; sampled only when idle.
- `sub` in 1: 0 = add, 1 = subtract; sampled with `start`.
- `a` in WIDTH: operand A, unsigned or two's complement; sampled with `start`.
- `b` in WIDTH: operand B; sampled with `start`.
- `cin` in 1: carry-in (add) or borrow-in (sub); sampled with `start`.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse when the result is valid.
- `s` out WIDTH: result.
- `cout` out 1: carry-out; in sub mode, 1 = no borrow.
- `ovf` out 1: signed overflow.

## Operation
- Arithmetic:
  - Add: `{cout,s} = a + b + cin`.
  - Sub: `s = a + ~b + ~cin`, i.e. `a − b − cin`. `cout` is the raw carry, so 0 means a borrow occurred.
  - Initial carry is `cin ^ sub`; the B operand is `b ^ {WIDTH{sub}}`.
- Datapath:
  - Internal A/B shift registers are shifted right by `DIGIT` each RUN cycle.
  - A `DIGIT`-bit ripple slice adds the low digits plus the carry register.
  - The sum digit enters the top of a result shift register.
  - The carry register is updated every RUN cycle.
- `ovf` = carry into the MSB XOR carry out of the MSB, captured from the final digit.
- FSM states IDLE and RUN:
  - IDLE: if `start`, latch operands into the shift registers, set the carry register to `cin^sub`, set `cnt=0`, go to RUN.
  - RUN: process one digit per cycle and increment `cnt`. When `cnt == N−1`, load `s`/`cout`/`ovf` from the final values, pulse `done`, and go to IDLE.
- `start` while in RUN is ignored: no queueing, no effect on the current operation.
- Outputs `s`, `cout`, `ovf` are held from `done` until the completion of the next accepted operation. They do not change during RUN.
- Reset (`rst_n` low at a clock edge), including mid-operation:
  - state → IDLE, `busy=0`, `done=0`, `s=0`, `cout=0`, `ovf=0`, `cnt=0`.
  - An aborted operation produces no `done`.

## Timing
- `start` is accepted at edge E0 (state IDLE). `busy` is high from after E0 until after edge E_N.
- Digits are processed at edges E1..E_N.
- After E_N: `done=1` for exactly one cycle, `busy=0`, and `s`/`cout`/`ovf` are valid.
- Latency from `start` edge to `done`: N cycles.
- Back-to-back: `start` asserted in the `done` cycle is accepted (state is IDLE), giving a throughput of one result per N+1 cycles.
- `DIGIT == WIDTH`: N=1, so `done` follows one cycle after acceptance.
- `busy` and `done` are never high together. `done` is never asserted without a prior accepted `start`.

## Test plan
- Add, defaults (8/2): `a=0x5A`, `b=0x3C`, `cin=0`, `sub=0` → `s=0x96`, `cout=0`, `ovf=1`. `done` 4 cycles after the start edge; `busy` high for exactly 4 cycles.
- Carry wrap: `a=0xFF`, `b=0x01`, `cin=0` → `s=0x00`, `cout=1`, `ovf=0`. Also `a=0xFF`, `b=0xFF`, `cin=1` → `s=0xFF`, `cout=1`, `ovf=0`.
- Subtract:
  - `0x10−0x20`, `cin=0` → `s=0xF0`, `cout=0` (borrow), `ovf=0`.
  - `0x80−0x01` → `s=0x7F`, `cout=1`, `ovf=1`.
  - `0x05−0x05`, `cin=1` → `s=0xFF`, `cout=0`.
- Handshake:
  - `start` pulsed mid-RUN with different operands → ignored; the first result is unchanged.
  - `start` asserted on the `done` cycle → second operation accepted, with `done` N cycles later.
  - `s` stays stable throughout RUN.
- Reset mid-operation: drop `rst_n` at digit 2 → all outputs 0 next cycle and no `done` pulse. A fresh start afterwards gives a correct result.
- Sweep: WIDTH=4 with DIGIT ∈ {1,2,4}, exhaustive `a`, `b`, `cin`, `sub` → every result matches the reference model for `{cout,s}` and `ovf`, with `done` latency = WIDTH/DIGIT.
